// File: rtl/block_layer_renderer.sv
// -----------------------------------------------------------------------------
// block_layer_renderer
//
// VGA timing generator plus stacked-block compositor running from one system
// clock. A clock divider produces a pixel tick; horizontal/vertical counters
// advance on that tick. Background pixels come from an external synchronous
// ROM, and up to N_BLOCKS outlined blocks are drawn on top. Block enables and
// column positions are snapshotted once per frame on the first blank line, so
// the game logic may change them at any time without tearing.
//
// Pixel path (each stage advances on tick only):
//   stage 0 : h_cnt / v_cnt           -> col / row
//   stage 1 : addr_bg, active, hs_raw, vs_raw, block hit / border
//   stage 2 : r/g/b, de, hs, vs        (2 ticks after the counters)
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   blocks_en    bit i enables block i
//   pos_blocks   column index of block i in [i*POS_W +: POS_W]
//   rgb_bg       background ROM data, valid one clk after addr_bg
//   addr_bg      background ROM address (v*H_ACTIVE + h while active, else 0)
//   hs, vs       active-low syncs
//   r, g, b      4-bit colour channels
//   de           display enable, aligned with r/g/b
//   row, col     stage-0 line / column counters
//   frame_start  one-clk pulse during the clk whose tick takes the snapshot
// -----------------------------------------------------------------------------
module block_layer_renderer #(
    parameter int          CLK_DIV    = 2,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          N_BLOCKS   = 12,
    parameter int          POS_W      = 5,
    parameter int          BLOCK_W    = 32,
    parameter int          BLOCK_H    = 24,
    parameter logic [11:0] BLOCK_RGB  = 12'hF80,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_BLOCKS-1:0]       blocks_en,
    input  logic [N_BLOCKS*POS_W-1:0] pos_blocks,
    input  logic [11:0]               rgb_bg,
    output logic [18:0]               addr_bg,
    output logic                      hs,
    output logic                      vs,
    output logic [3:0]                r,
    output logic [3:0]                g,
    output logic [3:0]                b,
    output logic                      de,
    output logic [8:0]                row,
    output logic [9:0]                col,
    output logic                      frame_start
);

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int N_COLS   = H_ACTIVE / BLOCK_W;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0]          div;
    logic                      tick;
    logic [9:0]                h_cnt;
    logic [9:0]                v_cnt;
    logic                      snap_take;
    logic [N_BLOCKS-1:0]       snap_en;
    logic [N_BLOCKS*POS_W-1:0] snap_pos;

    // Stage-0 combinational decode feeding stage 1.
    logic active0, hs_raw, vs_raw, hit0, border0;

    // Stage-1 registers.
    logic act1, hs1, vs1, hit1, border1;

    assign tick        = (div == DIV_W'(CLK_DIV - 1));
    assign snap_take   = tick && (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));
    assign frame_start = snap_take;
    assign col         = h_cnt;
    assign row         = v_cnt[8:0];

    assign active0 = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign hs_raw  = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
    assign vs_raw  = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));

    // Block hit test against the snapshot. Scanning from the highest index
    // down lets the lowest enabled index overwrite and win on overlap.
    always_comb begin
        hit0    = 1'b0;
        border0 = 1'b0;
        for (int i = N_BLOCKS - 1; i >= 0; i--) begin
            int pos, x0, y0, hh, vv;
            pos = int'(snap_pos[i*POS_W +: POS_W]);
            x0  = pos * BLOCK_W;
            y0  = V_ACTIVE - (i + 1) * BLOCK_H;
            hh  = int'(h_cnt);
            vv  = int'(v_cnt);
            // Out-of-range column or a block stacked above the screen top is clipped.
            if (snap_en[i] && (pos < N_COLS) && (y0 >= 0) &&
                (hh >= x0) && (hh < x0 + BLOCK_W) &&
                (vv >= y0) && (vv < y0 + BLOCK_H)) begin
                hit0    = 1'b1;
                border0 = (hh == x0) || (hh == x0 + BLOCK_W - 1) ||
                          (vv == y0) || (vv == y0 + BLOCK_H - 1);
            end
        end
    end

    // Divider, raster counters and per-frame snapshot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain stages in one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            snap_en  <= '0;
            snap_pos <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (h_cnt == 10'(H_TOT - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'(V_TOT - 1)) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
                if (snap_take) begin
                    snap_en  <= blocks_en;
                    snap_pos <= pos_blocks;
                end
            end
        end
    end

    // Stage 1: ROM address and decoded attributes.
    // Sync registers reset to the inactive level so no stray sync pulse
    // reaches the pins while the pipeline refills after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_bg <= '0;
            act1    <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            hit1    <= 1'b0;
            border1 <= 1'b0;
        end else if (tick) begin
            addr_bg <= active0 ? (19'(v_cnt) * 19'(H_ACTIVE) + 19'(h_cnt)) : '0;
            act1    <= active0;
            hs1     <= hs_raw;
            vs1     <= vs_raw;
            hit1    <= hit0;
            border1 <= border0;
        end
    end

    // Stage 2: registered pins. rgb_bg is valid here because at least one clk
    // separates the stage-1 tick from the stage-2 tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r, g, b} <= '0;
            de        <= 1'b0;
            hs        <= 1'b1;
            vs        <= 1'b1;
        end else if (tick) begin
            if (!act1)        {r, g, b} <= '0;
            else if (border1) {r, g, b} <= BORDER_RGB;
            else if (hit1)    {r, g, b} <= BLOCK_RGB;
            else              {r, g, b} <= rgb_bg;
            de <= act1;
            hs <= hs1;
            vs <= vs1;
        end
    end

endmodule

// File: tb/tb_block_layer_renderer.sv
// -----------------------------------------------------------------------------
// Testbench for block_layer_renderer, using a reduced raster so several frames
// fit in a short run. The reference model maps "ticks since reset" directly to
// a pixel index and evaluates the block rules on that pixel using the inputs
// recorded at the previous frame's snapshot point.
// -----------------------------------------------------------------------------
module tb_block_layer_renderer;

    localparam int          CLK_DIV    = 2;
    localparam int          H_ACTIVE   = 64;
    localparam int          H_FP       = 4;
    localparam int          H_SYNC     = 8;
    localparam int          H_BP       = 4;
    localparam int          V_ACTIVE   = 48;
    localparam int          V_FP       = 2;
    localparam int          V_SYNC     = 2;
    localparam int          V_BP       = 3;
    localparam int          N_BLOCKS   = 10;   // 10*6 > 48: top two blocks clipped
    localparam int          POS_W      = 4;    // positions 8..15 are off-screen
    localparam int          BLOCK_W    = 8;
    localparam int          BLOCK_H    = 6;
    localparam logic [11:0] BLOCK_RGB  = 12'hF80;
    localparam logic [11:0] BORDER_RGB = 12'h123;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FT    = H_TOT * V_TOT;       // ticks per frame

    logic                      clk;
    logic                      rst;
    logic [N_BLOCKS-1:0]       blocks_en;
    logic [N_BLOCKS*POS_W-1:0] pos_blocks;
    logic [11:0]               rgb_bg;
    logic [18:0]               addr_bg;
    logic                      hs, vs, de, frame_start;
    logic [3:0]                r, g, b;
    logic [8:0]                row;
    logic [9:0]                col;

    block_layer_renderer #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
        .H_BP(H_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
        .V_BP(V_BP), .N_BLOCKS(N_BLOCKS), .POS_W(POS_W), .BLOCK_W(BLOCK_W),
        .BLOCK_H(BLOCK_H), .BLOCK_RGB(BLOCK_RGB), .BORDER_RGB(BORDER_RGB)
    ) dut (
        .clk(clk), .rst(rst), .blocks_en(blocks_en), .pos_blocks(pos_blocks),
        .rgb_bg(rgb_bg), .addr_bg(addr_bg), .hs(hs), .vs(vs), .r(r), .g(g),
        .b(b), .de(de), .row(row), .col(col), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background ROM content: a cheap scramble of the address.
    function automatic logic [11:0] rom_data(input logic [18:0] a);
        logic [18:0] t;
        t = a * 19'd37 + (a >> 5);
        return t[11:0];
    endfunction

    // Synchronous ROM: one clk read latency.
    always @(posedge clk) rgb_bg <= rom_data(addr_bg);

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } pix_t;

    int n_checks = 0;
    int n_bad    = 0;
    int n;                                   // posedges since reset release

    logic [N_BLOCKS-1:0]       snap_en  [8];
    logic [N_BLOCKS*POS_W-1:0] snap_pos [8];
    bit                        snap_ok  [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected pins for pixel index p counted from reset release.
    function automatic pix_t exp_pix(input int p);
        int   h, v, f;
        pix_t e;
        h     = p % H_TOT;
        v     = (p / H_TOT) % V_TOT;
        f     = p / FT;
        e.hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        e.vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        e.de  = (h < H_ACTIVE) && (v < V_ACTIVE);
        e.rgb = 12'h000;
        if (e.de) begin
            e.rgb = rom_data(19'(v * H_ACTIVE + h));
            // Visible lines of frame f show what was captured during frame f-1.
            if (f >= 1 && snap_ok[f-1]) begin
                for (int i = 0; i < N_BLOCKS; i++) begin
                    int pos, x0, y0;
                    pos = int'(snap_pos[f-1][i*POS_W +: POS_W]);
                    x0  = pos * BLOCK_W;
                    y0  = V_ACTIVE - (i + 1) * BLOCK_H;
                    if (snap_en[f-1][i] && pos < H_ACTIVE / BLOCK_W && y0 >= 0 &&
                        h >= x0 && h < x0 + BLOCK_W && v >= y0 && v < y0 + BLOCK_H) begin
                        e.rgb = (h == x0 || h == x0 + BLOCK_W - 1 ||
                                 v == y0 || v == y0 + BLOCK_H - 1) ? BORDER_RGB : BLOCK_RGB;
                        break;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".hs"},  32'(hs), 32'd1);
        check({tag, ".vs"},  32'(vs), 32'd1);
        check({tag, ".de"},  32'(de), 32'd0);
        check({tag, ".rgb"}, 32'({r, g, b}), 32'd0);
        check({tag, ".addr"}, 32'(addr_bg), 32'd0);
        check({tag, ".fs"},  32'(frame_start), 32'd0);
        check({tag, ".col"}, 32'(col), 32'd0);
        check({tag, ".row"}, 32'(row), 32'd0);
    endtask

    task automatic check_cycle();
        int   t, ph, pv;
        pix_t e;
        logic fs;
        logic [31:0] ea;
        t = n / CLK_DIV;
        check("col", 32'(col), 32'(t % H_TOT));
        check("row", 32'(row), 32'(((t / H_TOT) % V_TOT) % 512));
        if (t >= 2) e = exp_pix(t - 2);
        else        e = '{1'b1, 1'b1, 1'b0, 12'h000};
        check("hs",  32'(hs), 32'(e.hs));
        check("vs",  32'(vs), 32'(e.vs));
        check("de",  32'(de), 32'(e.de));
        check("rgb", 32'({r, g, b}), 32'(e.rgb));
        ea = 32'd0;
        if (t >= 1) begin
            ph = (t - 1) % H_TOT;
            pv = ((t - 1) / H_TOT) % V_TOT;
            if (ph < H_ACTIVE && pv < V_ACTIVE) ea = 32'(pv * H_ACTIVE + ph);
        end
        check("addr_bg", 32'(addr_bg), ea);
        fs = ((n + 1) % CLK_DIV == 0) && (t % H_TOT == 0) &&
             ((t / H_TOT) % V_TOT == V_ACTIVE);
        check("frame_start", 32'(frame_start), 32'(fs));
        // The DUT latches at the next edge, so record what is being driven now.
        if (fs) begin
            snap_en[t / FT]  = blocks_en;
            snap_pos[t / FT] = pos_blocks;
            snap_ok[t / FT]  = 1'b1;
        end
    endtask

    task automatic randomize_inputs();
        blocks_en = N_BLOCKS'($urandom);
        for (int i = 0; i < N_BLOCKS; i++)
            pos_blocks[i*POS_W +: POS_W] = POS_W'($urandom_range(0, 11));
    endtask

    // Release reset at the current negedge and run n_clks clocks with checks.
    task automatic run_segment(input int n_clks, input bit directed);
        int t;
        n = 0;
        for (int i = 0; i < 8; i++) snap_ok[i] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < n_clks; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            t = n / CLK_DIV;
            if (directed && t < 2 * FT) begin
                // Move block 0 from column 3 to 5 partway through frame 1.
                if (t == FT + 20 * H_TOT) pos_blocks[POS_W-1:0] = POS_W'(5);
            end else if ($urandom_range(0, 299) == 0) begin
                randomize_inputs();
            end
            check_cycle();
        end
    endtask

    initial begin
        rst        = 1'b1;
        blocks_en  = N_BLOCKS'(1);
        pos_blocks = '0;
        pos_blocks[POS_W-1:0] = POS_W'(3);

        repeat (5) begin
            @(negedge clk);
            check_reset("reset");
        end

        // Single block at column 3, tear-free move, then random traffic;
        // ends 30 lines into frame 3.
        run_segment(3 * FT * CLK_DIV + 30 * H_TOT * CLK_DIV, 1'b1);

        // Mid-frame reset: outputs must clear without waiting for a clock.
        rst = 1'b1;
        blocks_en = '1;
        randomize_inputs();
        #1;
        check_reset("midrst");
        repeat (3) begin
            @(negedge clk);
            check_reset("midrst_hold");
        end

        // After reset no block may appear until the first new snapshot.
        run_segment(2 * FT * CLK_DIV + 200, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/block_layer_renderer.md
Name: block_layer_renderer

Overview:
- Parametrised successor to the BuildingDrops print path: one-clock VGA timing generator plus stacked-block compositor.
- Generates an internal pixel tick (no separate vga_clk), fetches background pixels from a synchronous ROM, and overlays up to N_BLOCKS stacked blocks with borders.
- Block enables and positions are snapshotted once per frame, so game logic may update them at any time without tearing.
- Sits between the game FSM (blocks/pos outputs) and the board VGA pins.

Parameters:
- CLK_DIV, 2, clk cycles per pixel tick (must be ≥2).
- H_ACTIVE, 640, visible columns.
- H_FP, 16, horizontal front porch, in ticks.
- H_SYNC, 96, horizontal sync width, in ticks.
- H_BP, 48, horizontal back porch, in ticks.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- N_BLOCKS, 12, number of stackable blocks.
- POS_W, 5, width of each block's column index.
- BLOCK_W, 32, block width in pixels.
- BLOCK_H, 24, block height in pixels.
- BLOCK_RGB, 12'hF80, block fill colour.
- BORDER_RGB, 12'h000, block 1-pixel outline colour.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- blocks_en, in, N_BLOCKS, bit i enables block i.
- pos_blocks, in, N_BLOCKS*POS_W, column index of block i in bits [i*POS_W +: POS_W].
- rgb_bg, in, 12, background ROM data; valid 1 clk after addr_bg.
- addr_bg, out, 19, background ROM address.
- hs, out, 1, horizontal sync, active low.
- vs, out, 1, vertical sync, active low.
- r, out, 4, red.
- g, out, 4, green.
- b, out, 4, blue.
- de, out, 1, display enable, aligned with r/g/b.
- row, out, 9, stage-0 line counter (low 9 bits of v_cnt).
- col, out, 10, stage-0 column counter.
- frame_start, out, 1, 1-clk pulse on the tick at which the snapshot is taken.

Behaviour:
- Reset (async, high): divider, h_cnt, v_cnt, and all pipeline registers are cleared to 0. Outputs: hs=1, vs=1, de=0, r=g=b=0, addr_bg=0, frame_start=0. Snapshot regs = 0, so no blocks are drawn.
- Tick: the divider counts 0..CLK_DIV-1; tick=1 when divider==CLK_DIV-1. All pixel-path registers advance only on tick.
- Counters: h_cnt counts 0..H_TOT-1 and wraps, where H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP. v_cnt increments when h_cnt wraps and itself wraps at V_TOT.
- Stage 0: h_cnt/v_cnt, which drive row/col directly.
- Stage 1: registers addr_bg = v_cnt*H_ACTIVE + h_cnt when active, else 0. Also registers active, hs_raw, vs_raw, and the block-hit result.
  - hs_raw=0 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw=0 for v_cnt in the analogous line range.
- Stage 2: registers the outputs. Because CLK_DIV≥2, rgb_bg is valid at this stage.
  - Colour priority: border if hit_border; else BLOCK_RGB if hit; else rgb_bg. Output 0 when not active.
  - de/hs/vs are the stage-1 values, delayed one tick.
  - Total latency from counter to pins: 2 ticks. hs/vs/de/rgb are mutually aligned.
- Block geometry, block i:
  - x0 = pos_i*BLOCK_W; y0 = V_ACTIVE-(i+1)*BLOCK_H.
  - hit when en_i, pos_i < H_ACTIVE/BLOCK_W, y0 ≥ 0, x0 ≤ h < x0+BLOCK_W, and y0 ≤ v < y0+BLOCK_H.
  - Border = hit with h==x0, h==x0+BLOCK_W-1, v==y0, or v==y0+BLOCK_H-1.
  - Clipped blocks (pos out of range or y0<0) are never drawn.
  - The lowest index wins on overlap.
- Snapshot: on the tick where h_cnt==0 and v_cnt==V_ACTIVE (first blank line), latch blocks_en and pos_blocks, and pulse frame_start for that clk. Input changes at any other time are invisible until the next snapshot.
- Reset mid-frame: all state clears immediately. The next frame starts from h=v=0 with no blocks shown until the first snapshot.
- Arithmetic: the address is computed unsigned at 19 bits. The multiply by H_ACTIVE is a constant multiply; shift-add is acceptable.

Test Plan:
- Reset check: hold rst=1 for 5 clk → hs=vs=1, de=0, rgb=0, addr_bg=0. Release rst → first tick occurs 2 clk later; col increments every 2 clk.
- Sync timing (defaults): hs low for exactly 192 clk, period 1600 clk. vs low for 2 lines (3200 clk), frame period 840000 clk. de high for 1280 clk per active line.
- Single block: blocks_en=1, pos_0=3, rgb_bg=12'h0F0, let one snapshot pass.
  - Next frame: pixels col 97..126, rows 457..478 output F80.
  - col 96, col 127, row 456, and row 479 output 000.
  - col 95 outputs 0F0.
  - Check alignment against de with 2-tick latency.
- Clipping: pos_0=20 or N_BLOCKS*BLOCK_H > V_ACTIVE → the out-of-range block never appears, and frame_start still pulses.
- Tear-free: change pos_0 from 3 to 5 at v=200 → the rest of the frame still shows column 3; the next frame shows column 5. frame_start pulses once per 840000 clk.
- Mid-frame reset: assert rst at v=300 → outputs return to reset values within the same clk. After release, no blocks are drawn until the first snapshot at v=480.
